// File: rtl/crack_sequencer.sv
// Brute-force candidate sequencer: walks a 4-digit base-ALPHA counter, issues
// candidates to a pipelined hash/compare unit and tracks in-order results.
module crack_sequencer #(
    parameter int MAX_OUT = 4,
    parameter int ALPHA   = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [5:0]  a,
    output logic [5:0]  b,
    output logic [5:0]  c,
    output logic [5:0]  d,
    output logic        cand_valid,
    input  logic        cand_ready,
    input  logic        res_valid,
    input  logic        res_match,
    output logic        busy,
    output logic        found,
    output logic        exhausted,
    output logic [23:0] found_word,
    output logic [18:0] tested
);

    // state   | meaning
    // S_IDLE  | waiting for start after reset
    // S_RUN   | issuing candidates and collecting results
    // S_DRAIN | no issue; collecting remaining results after match/abort
    // S_DONE  | results held until the next start
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam int PW = $clog2(MAX_OUT);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);
    localparam logic [5:0]    LAST_SYM  = 6'(ALPHA - 1);
    localparam logic [23:0]   LAST_CAND = {LAST_SYM, LAST_SYM, LAST_SYM, LAST_SYM};

    state_t        state_q, state_d;
    logic [23:0]   cnt_q, cnt_d;
    logic          last_q, last_d;
    logic [OW-1:0] out_q, out_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [23:0]   fifo_q [MAX_OUT];
    logic [23:0]   fifo_d [MAX_OUT];
    logic          found_q, found_d;
    logic          exh_q, exh_d;
    logic [23:0]   fw_q, fw_d;
    logic [18:0]   tested_q, tested_d;

    logic          valid_c;
    logic          xfer;
    logic          pop;
    logic [23:0]   head;

    function automatic logic [23:0] next_cand(input logic [23:0] v);
        logic [23:0] r;
        r = v;
        if (v[5:0] != LAST_SYM) begin
            r[5:0] = v[5:0] + 6'd1;
        end else begin
            r[5:0] = 6'd0;
            if (v[11:6] != LAST_SYM) begin
                r[11:6] = v[11:6] + 6'd1;
            end else begin
                r[11:6] = 6'd0;
                if (v[17:12] != LAST_SYM) begin
                    r[17:12] = v[17:12] + 6'd1;
                end else begin
                    r[17:12] = 6'd0;
                    r[23:18] = v[23:18] + 6'd1;
                end
            end
        end
        return r;
    endfunction

    assign valid_c = (state_q == S_RUN) && (out_q < MAX_OUT_C) && !last_q;
    assign xfer    = valid_c && cand_ready;
    assign pop     = res_valid && (out_q != '0);
    assign head    = fifo_q[rd_q];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        out_d    = out_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        fifo_d   = fifo_q;
        found_d  = found_q;
        exh_d    = exh_q;
        fw_d     = fw_q;
        tested_d = tested_q;

        if (xfer) begin
            fifo_d[wr_q] = cnt_q;
            wr_d = wr_q + PW'(1);
            // counter parks on the final candidate instead of wrapping to zero
            if (cnt_q == LAST_CAND) begin
                last_d = 1'b1;
            end else begin
                cnt_d = next_cand(cnt_q);
            end
        end

        if (pop) begin
            rd_d = rd_q + PW'(1);
            if (tested_q != '1) begin
                tested_d = tested_q + 19'd1;
            end
        end

        if (xfer && !pop) begin
            out_d = out_q + OW'(1);
        end else if (pop && !xfer) begin
            out_d = out_q - OW'(1);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    last_d   = 1'b0;
                    out_d    = '0;
                    wr_d     = '0;
                    rd_d     = '0;
                    found_d  = 1'b0;
                    exh_d    = 1'b0;
                    fw_d     = '0;
                    tested_d = '0;
                end
            end
            S_RUN: begin
                // a match outranks a simultaneous abort
                if (pop && res_match) begin
                    found_d = 1'b1;
                    fw_d    = head;
                    state_d = S_DRAIN;
                end else if (abort) begin
                    state_d = S_DRAIN;
                end else if (last_d && (out_d == '0)) begin
                    exh_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DRAIN: begin
                if (out_d == '0) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            out_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            for (int i = 0; i < MAX_OUT; i++) begin
                fifo_q[i] <= '0;
            end
            found_q  <= 1'b0;
            exh_q    <= 1'b0;
            fw_q     <= '0;
            tested_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            out_q    <= out_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            fifo_q   <= fifo_d;
            found_q  <= found_d;
            exh_q    <= exh_d;
            fw_q     <= fw_d;
            tested_q <= tested_d;
        end
    end

    assign a          = cnt_q[23:18];
    assign b          = cnt_q[17:12];
    assign c          = cnt_q[11:6];
    assign d          = cnt_q[5:0];
    assign cand_valid = valid_c;
    assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign found      = found_q;
    assign exhausted  = exh_q;
    assign found_word = fw_q;
    assign tested     = tested_q;

endmodule

// File: tb/tb_crack_sequencer.sv
// Bench for crack_sequencer: a modelled downstream unit returns in-order results
// from a pending queue; a small-alphabet instance covers the exhaustive run.
module tb_crack_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        start = 1'b0, abort = 1'b0;
    logic        cand_ready = 1'b0, res_valid = 1'b0, res_match = 1'b0;
    logic [5:0]  a, b, c, d;
    logic        cand_valid, busy, found, exhausted;
    logic [23:0] found_word;
    logic [18:0] tested;

    logic        s_start = 1'b0, s_cand_ready = 1'b0, s_res_valid = 1'b0;
    logic        s_abort = 1'b0, s_res_match = 1'b0;
    logic [5:0]  s_a, s_b, s_c, s_d;
    logic        s_cand_valid, s_busy, s_found, s_exhausted;
    logic [23:0] s_found_word;
    logic [18:0] s_tested;

    crack_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .a(a), .b(b), .c(c), .d(d), .cand_valid(cand_valid), .cand_ready(cand_ready),
        .res_valid(res_valid), .res_match(res_match), .busy(busy), .found(found),
        .exhausted(exhausted), .found_word(found_word), .tested(tested)
    );

    crack_sequencer #(.MAX_OUT(4), .ALPHA(3)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
        .a(s_a), .b(s_b), .c(s_c), .d(s_d), .cand_valid(s_cand_valid),
        .cand_ready(s_cand_ready), .res_valid(s_res_valid), .res_match(s_res_match),
        .busy(s_busy), .found(s_found), .exhausted(s_exhausted),
        .found_word(s_found_word), .tested(s_tested)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] idx2cand(input int i, input int base);
        int          q;
        logic [23:0] r;
        q = i;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[k*6 +: 6] = 6'(q % base);
            q = q / base;
        end
        return r;
    endfunction

    // controls written only by the sequencing process
    logic        withhold = 1'b0, ready_random = 1'b0, match_en = 1'b0;
    logic        match_counts = 1'b0, stray_res = 1'b0;
    logic [23:0] target = '0;
    int          ready_limit = 1 << 30;
    int          release_req = 0;

    // state written only by the responder
    typedef struct { logic [23:0] cand; int due; } pend_t;
    pend_t       pend[$];
    logic [23:0] exp_found[$];
    logic [23:0] s_pend[$];
    int          cyc = 0, exp_idx = 0, xfer_cnt = 0, res_sent = 0, release_done = 0;
    int          s_idx = 0, s_xfers = 0;
    logic        prev_stall = 1'b0, prev_busy = 1'b0, wrap1 = 1'b0, wrap2 = 1'b0;
    logic [23:0] held = '0, last_cand = '0, s_last = '0, cur;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            pend.delete();
            s_pend.delete();
            prev_stall = 1'b0;
        end
        if (busy && !prev_busy) begin
            exp_idx  = 0;
            xfer_cnt = 0;
            res_sent = 0;
        end

        cand_ready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
        if (xfer_cnt >= ready_limit) cand_ready = 1'b0;

        cur = {a, b, c, d};
        if (prev_stall && cand_valid) chk("hold", cur, held);
        if (cand_valid && cand_ready) begin
            chk("cand", cur, idx2cand(exp_idx, 26));
            if (cur == 24'h000040 && last_cand == 24'h000019) wrap1 = 1'b1;
            if (cur == 24'h040000 && last_cand == 24'h019659) wrap2 = 1'b1;
            last_cand = cur;
            pend.push_back('{cand: cur, due: cyc + 3});
            exp_idx++;
            xfer_cnt++;
        end
        prev_stall = cand_valid && !cand_ready;
        held = cur;

        res_valid = 1'b0;
        res_match = 1'b0;
        if (stray_res) begin
            res_valid = 1'b1;
            res_match = 1'b1;
        end else if (pend.size() > 0 && pend[0].due <= cyc &&
                     (!withhold || release_done < release_req)) begin
            if (withhold) release_done++;
            res_valid = 1'b1;
            res_match = match_en && (pend[0].cand == target);
            if (res_match && match_counts) exp_found.push_back(pend[0].cand);
            void'(pend.pop_front());
            res_sent++;
        end

        s_cand_ready = 1'b1;
        s_res_valid  = 1'b0;
        if (s_pend.size() > 0) begin
            s_res_valid = 1'b1;
            void'(s_pend.pop_front());
        end
        if (s_cand_valid && s_cand_ready) begin
            chk("s_cand", {s_a, s_b, s_c, s_d}, idx2cand(s_idx, 3));
            s_pend.push_back({s_a, s_b, s_c, s_d});
            s_last = {s_a, s_b, s_c, s_d};
            s_idx++;
            s_xfers++;
        end
        prev_busy = busy;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (busy && n < max) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, 32'(busy), 0);
    endtask

    task automatic wait_xfer(input string tag, input int n, input int max);
        int k = 0;
        while (xfer_cnt < n && k < max) begin
            tick();
            k++;
        end
        chk({tag, "_timeout"}, 32'(xfer_cnt >= n), 1);
    endtask

    initial begin
        int k;
        repeat (3) tick();
        chk("rst_valid", 32'(cand_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_found", 32'(found), 0);
        chk("rst_exh", 32'(exhausted), 0);
        chk("rst_fw", 32'(found_word), 0);
        chk("rst_tested", 32'(tested), 0);
        chk("rst_abcd", {a, b, c, d}, 0);
        rst = 1'b1;
        repeat (5) tick();
        chk("idle_hold", 32'(busy), 0);

        // exhaustive search on a 3-symbol alphabet: 81 candidates
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        k = 0;
        while (s_busy && k < 2000) begin
            tick();
            k++;
        end
        chk("s_timeout", 32'(s_busy), 0);
        chk("s_exh", 32'(s_exhausted), 1);
        chk("s_found", 32'(s_found), 0);
        chk("s_tested", 32'(s_tested), 81);
        chk("s_xfers", s_xfers, 81);
        chk("s_last", s_last, 24'h082082);
        chk("s_valid_done", 32'(s_cand_valid), 0);

        // match on 0,0,1,2 with 3-cycle result latency
        target = 24'h000042;
        match_en = 1'b1;
        match_counts = 1'b1;
        pulse_start();
        wait_idle("match", 500);
        chk("m_found", 32'(found), 1);
        chk("m_exh", 32'(exhausted), 0);
        chk("m_fw", found_word, 24'h000042);
        chk("m_tested", 32'(tested), res_sent);
        chk("m_sb_size", exp_found.size(), 1);
        if (exp_found.size() > 0) chk("m_sb_word", found_word, exp_found[0]);
        chk("m_valid_done", 32'(cand_valid), 0);
        match_counts = 1'b0;
        match_en = 1'b0;

        // withheld results cap issue at MAX_OUT; one release admits one more
        withhold = 1'b1;
        pulse_start();
        repeat (20) tick();
        chk("wh_xfers", xfer_cnt, 4);
        chk("wh_valid", 32'(cand_valid), 0);
        release_req++;
        repeat (10) tick();
        chk("rel_xfers", xfer_cnt, 5);
        chk("rel_valid", 32'(cand_valid), 0);
        pulse_abort();
        withhold = 1'b0;
        wait_idle("wh_drain", 100);
        chk("wh_found", 32'(found), 0);
        chk("wh_tested", 32'(tested), 5);

        // abort with 3 outstanding; a matching result during drain is ignored
        withhold = 1'b1;
        ready_limit = 3;
        pulse_start();
        repeat (12) tick();
        chk("ab_xfers", xfer_cnt, 3);
        pulse_abort();
        chk("ab_drain_busy", 32'(busy), 1);
        target = idx2cand(1, 26);
        match_en = 1'b1;
        withhold = 1'b0;
        ready_limit = 1 << 30;
        wait_idle("ab_drain", 100);
        chk("ab_found", 32'(found), 0);
        chk("ab_exh", 32'(exhausted), 0);
        chk("ab_tested", 32'(tested), 3);
        match_en = 1'b0;

        // random backpressure across the digit wraps
        ready_random = 1'b1;
        pulse_start();
        wait_xfer("rnd", 17578, 70000);
        pulse_abort();
        ready_random = 1'b0;
        wait_idle("rnd_drain", 100);
        chk("wrap_d_to_c", 32'(wrap1), 1);
        chk("wrap_b_to_a", 32'(wrap2), 1);
        chk("rnd_tested", 32'(tested), res_sent);
        chk("rnd_both", 32'(found && exhausted), 0);

        // reset mid-run with 2 outstanding
        withhold = 1'b1;
        ready_limit = 2;
        pulse_start();
        repeat (8) tick();
        chk("mr_xfers", xfer_cnt, 2);
        rst = 1'b0;
        #1;
        chk("mr_valid", 32'(cand_valid), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_abcd", {a, b, c, d}, 0);
        chk("mr_tested", 32'(tested), 0);
        chk("mr_found", 32'(found), 0);
        tick();
        rst = 1'b1;
        withhold = 1'b0;
        ready_limit = 1 << 30;
        stray_res = 1'b1;
        repeat (3) tick();
        stray_res = 1'b0;
        tick();
        chk("stray_busy", 32'(busy), 0);
        chk("stray_tested", 32'(tested), 0);
        chk("stray_found", 32'(found), 0);
        pulse_start();
        wait_xfer("restart", 3, 50);
        pulse_abort();
        wait_idle("restart_drain", 100);
        chk("restart_tested", 32'(tested), res_sent);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
